// File: rtl/rf_access_pkg.sv
// rf_access_pkg: FSM state encoding, register-file control codes and parameter defaults
package rf_access_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [1:0] RF_RW_IDLE  = 2'b00;
    localparam logic [1:0] RF_RW_WRITE = 2'b01;
    localparam logic [1:0] RF_RW_READ  = 2'b10;
    localparam logic [1:0] RF_RW_BOTH  = 2'b11;
    typedef enum logic [2:0] {IDLE, WRITE, READ1, READ2, RESP} state_t;
endpackage

// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: request/response handshake plus register-file control bus
// slave  = controller side: takes req_*, drives rsp_* and rf_* controls, takes rf read data
// master = requester/register-file side (the mirror image)
interface rf_access_ctrl_if
    import rf_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic              req_we;
    logic [ADDR_W-1:0] req_rd;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_op1;
    logic [DATA_W-1:0] rsp_op2;
    logic [1:0]        rf_read_or_write;
    logic [ADDR_W-1:0] rf_read_addr_1;
    logic [ADDR_W-1:0] rf_read_addr_2;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_read_data_1;
    logic [DATA_W-1:0] rf_read_data_2;
    modport slave (
        input  req_valid, req_rs1, req_rs2, req_we, req_rd, req_wdata, rsp_ready,
               rf_read_data_1, rf_read_data_2,
        output req_ready, rsp_valid, rsp_op1, rsp_op2, rf_read_or_write,
               rf_read_addr_1, rf_read_addr_2, rf_write_addr, rf_write_data
    );
    modport master (
        output req_valid, req_rs1, req_rs2, req_we, req_rd, req_wdata, rsp_ready,
               rf_read_data_1, rf_read_data_2,
        input  req_ready, rsp_valid, rsp_op1, rsp_op2, rf_read_or_write,
               rf_read_addr_1, rf_read_addr_2, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequences an optional register write and two operand reads per request
// Ports: clk, rst (sync, active-high), bus (rf_access_ctrl_if.slave: req/rsp handshakes + rf control)
// Option: RF_BYPASS_EN merges the write into READ1 and forwards req_wdata to matching operands
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic            clk,
    input  logic            rst,
    rf_access_ctrl_if.slave bus
);
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd;
    logic [DATA_W-1:0] r_wdata, r_op1, r_op2;
    logic              r_we;
    logic              w_wr_en;
    logic              w_hit1, w_hit2;
    logic [DATA_W-1:0] w_op1, w_op2;
    logic [1:0]        w_rw;
    // R0 is hard-wired zero, so a write to it is dropped entirely
    assign w_wr_en = r_we && (r_rd != '0);
    // the register file returns pre-write data when write and read share an edge
    assign w_hit1  = BYPASS && w_wr_en && (r_rs1 == r_rd);
    assign w_hit2  = BYPASS && w_wr_en && (r_rs2 == r_rd);
    assign w_op1   = (r_rs1 == '0) ? '0 : w_hit1 ? r_wdata : bus.rf_read_data_1;
    assign w_op2   = (r_rs2 == '0) ? '0 : w_hit2 ? r_wdata : bus.rf_read_data_2;
    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE)  ? (!bus.req_valid ? IDLE :
                                       (!BYPASS && bus.req_we && bus.req_rd != '0) ? WRITE : READ1) :
                 (r_state == WRITE) ? READ1 :
                 (r_state == READ1) ? READ2 :
                 (r_state == READ2) ? RESP :
                 (r_state == RESP)  ? (bus.rsp_ready ? IDLE : RESP) : IDLE;
    end
    always_comb begin
        w_rw = RF_RW_IDLE;
        w_rw = (r_state == WRITE) ? RF_RW_WRITE :
               (r_state == READ1) ? ((BYPASS && w_wr_en) ? RF_RW_BOTH : RF_RW_READ) :
               (r_state == READ2) ? RF_RW_READ : RF_RW_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) begin
                r_rs1   <= bus.req_rs1;
                r_rs2   <= bus.req_rs2;
                r_rd    <= bus.req_rd;
                r_we    <= bus.req_we;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == READ2) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
        end
    end
    // outputs are gated by rst so nothing leaks (notably no write) while reset is held
    assign bus.req_ready        = !rst && (r_state == IDLE);
    assign bus.rsp_valid        = !rst && (r_state == RESP);
    assign bus.rsp_op1          = rst ? '0 : r_op1;
    assign bus.rsp_op2          = rst ? '0 : r_op2;
    assign bus.rf_read_or_write = rst ? RF_RW_IDLE : w_rw;
    assign bus.rf_read_addr_1   = rst ? '0 : r_rs1;
    assign bus.rf_read_addr_2   = rst ? '0 : r_rs2;
    assign bus.rf_write_addr    = rst ? '0 : r_rd;
    assign bus.rf_write_data    = rst ? '0 : r_wdata;
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: randomized self-checking bench with a register-file model and a shadow array reference
module tb_rf_access_ctrl;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    int   both_cnt = 0;
    logic [31:0] model [32];
    // R0 holds garbage here so that the operand zero-forcing is actually exercised
    logic [31:0] mem [32] = '{0: 32'hDEAD_BEEF, default: 32'h0};
    always #5 clk = ~clk;
    rf_access_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    rf_access_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always @(posedge clk) begin
        if (bus.rf_read_or_write[0]) mem[bus.rf_write_addr] <= bus.rf_write_data;
        if (bus.rf_read_or_write[1]) begin
            bus.rf_read_data_1 <= mem[bus.rf_read_addr_1];
            bus.rf_read_data_2 <= mem[bus.rf_read_addr_2];
        end
        if (bus.rf_read_or_write[0]) wr_cnt <= wr_cnt + 1;
        if (bus.rf_read_or_write == 2'b11) both_cnt <= both_cnt + 1;
    end
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic do_req(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input int hold);
        int lat, w0, b0;
        bit wr;
        logic [31:0] e1, e2;
        wr = we && rd != 5'd0;
        if (wr) model[rd] = wd;
        e1 = (rs1 == 5'd0) ? 32'h0 : model[rs1];
        e2 = (rs2 == 5'd0) ? 32'h0 : model[rs2];
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_rd = rd;
        bus.req_wdata = wd;
        bus.req_rs1 = rs1;
        bus.req_rs2 = rs2;
        chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        w0 = wr_cnt;
        b0 = both_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            if (bus.req_ready) chk("req_ready_busy", {31'h0, bus.req_ready}, 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (!BYP && wr) ? 32'd4 : 32'd3);
        chk("op1", bus.rsp_op1, e1);
        chk("op2", bus.rsp_op2, e2);
        chk("rf_writes", wr_cnt - w0, wr ? 32'd1 : 32'd0);
        chk("rf_both", both_cnt - b0, (BYP && wr) ? 32'd1 : 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
            chk("hold_op1", bus.rsp_op1, e1);
            chk("hold_op2", bus.rsp_op2, e2);
            chk("hold_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'h0, bus.rsp_valid}, 32'h0);
    endtask
    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
        chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
        chk({tag, "_op1"}, bus.rsp_op1, 32'h0);
        chk({tag, "_op2"}, bus.rsp_op2, 32'h0);
        chk({tag, "_rw"}, {30'h0, bus.rf_read_or_write}, 32'h0);
        chk({tag, "_ra1"}, {27'h0, bus.rf_read_addr_1}, 32'h0);
        chk({tag, "_ra2"}, {27'h0, bus.rf_read_addr_2}, 32'h0);
        chk({tag, "_wa"}, {27'h0, bus.rf_write_addr}, 32'h0);
        chk({tag, "_wd"}, bus.rf_write_data, 32'h0);
    endtask
    initial begin
        int w0;
        logic [4:0] rd, rs1, rs2;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_rd = '0;
        bus.req_wdata = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
        for (int i = 0; i < 32; i++) do_req(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 0);
        do_req(1'b1, 5'd1, 32'hF0F0_F0F0, 5'd1, 5'd0, 0);
        do_req(1'b1, 5'd0, 32'h0F0F_0F0F, 5'd0, 5'd0, 0);
        do_req(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd0, 5'd5, 0);
        do_req(1'b1, 5'd2, 32'h1357_9BDF, 5'd1, 5'd2, 5);
        do_req(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd31, 0);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_rd = 5'd5;
        bus.req_wdata = 32'hBAD0_BAD0;
        bus.req_rs1 = 5'd5;
        bus.req_rs2 = 5'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        w0 = wr_cnt;
        rst = 1'b1;
        #1;
        chk_zero_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_write", wr_cnt - w0, 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", {31'h0, bus.req_ready}, 32'h1);
        do_req(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 0);
        for (int i = 0; i < 40; i++) begin
            rd = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            do_req(1'($urandom_range(0, 1)), rd, $urandom, rs1, rs2, int'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-008 SHALL have ports req_rs1 and req_rs2, input, ADDR_W, operand source addresses.
REQ-009 SHALL have ports req_we (input, 1), req_rd (input, ADDR_W) and req_wdata (input, DATA_W), for an optional write of req_wdata to req_rd.
REQ-010 SHALL have port rsp_valid, output, 1, operands valid.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts the operands.
REQ-012 SHALL have ports rsp_op1 and rsp_op2, output, DATA_W, operand values.
REQ-013 SHALL have port rf_read_or_write, output, 2, register-file control: bit1 = read enable, bit0 = write enable.
REQ-014 SHALL have ports rf_read_addr_1 and rf_read_addr_2 (output, ADDR_W), rf_write_addr (output, ADDR_W) and rf_write_data (output, DATA_W), driven to the register file.
REQ-015 SHALL have ports rf_read_data_1 and rf_read_data_2, input, DATA_W, register-file read data, valid one cycle after the read enable is asserted.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, READ1, READ2 and RESP.
REQ-017 SHALL, in IDLE, hold req_ready=1 and drive rf_read_or_write=00; on req_valid&&req_ready it SHALL latch all req_* fields and go to WRITE if req_we && req_rd!=0, else to READ1.
REQ-018 SHALL, in WRITE, drive rf_read_or_write=01 with the latched rd and wdata for exactly one cycle, then go to READ1; writes to R0 are never issued.
REQ-019 SHALL, in READ1 and READ2, drive rf_read_or_write=10 with the latched rs1/rs2, capture rf_read_data_1/2 into rsp_op1/2 at the end of READ2, then go to RESP.
REQ-020 SHALL force an operand to 0 when its source address is 0, regardless of the register-file data.
REQ-021 SHALL, in RESP, hold rsp_valid=1 with rsp_op1/2 stable until rsp_ready=1, then return to IDLE; req_ready=0 in every state except IDLE.
REQ-022 SHALL have latency from the accept edge to rsp_valid of 4 cycles with a write and 3 cycles without; throughput is one request per latency+1 cycles at best.
REQ-023 SHALL, when rd equals rs1 or rs2, return the newly written value (write precedes read).

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, req_ready=0, rsp_valid=0, rsp_op1/2=0, rf_read_or_write=00 and all rf addresses and rf_write_data=0.
REQ-025 SHALL, on reset asserted mid-transaction, abandon the transaction without issuing any further register-file write; req_ready=1 in the first cycle after rst falls.

Configuration
REQ-026 SHALL, with RF_BYPASS_EN defined, skip WRITE: READ1 drives rf_read_or_write=11 (write and read together), and an operand whose nonzero address equals a written rd takes req_wdata directly; latency is 3 cycles in all cases.
REQ-027 SHALL, without RF_BYPASS_EN, behave exactly as REQ-017 to REQ-023.

Structure
REQ-028 SHALL place the following in the shared package rf_access_pkg: the FSM state encoding, RF_RW_IDLE=2'b00, RF_RW_WRITE=2'b01, RF_RW_READ=2'b10, RF_RW_BOTH=2'b11, and the defaults for DATA_W and ADDR_W.
REQ-029 SHALL be implemented as a single module with no sub-module; the bench instantiates it together with Register_File.

Verification
REQ-030 SHALL cover: we=1, rd=1, wdata=F0F0F0F0, rs1=1, rs2=0 -> rsp_op1=F0F0F0F0 and rsp_op2=0, with rsp_valid 4 cycles after the accept edge.
REQ-031 SHALL cover: we=1, rd=0, wdata=0F0F0F0F, rs1=0 -> no cycle with rf_read_or_write bit0=1, and rsp_op1=0.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and the operands stay stable and req_ready stays 0 until the handshake.
REQ-033 SHALL cover: rst asserted during WRITE -> no write reaches the register file, all outputs are 0, and a subsequent read of that rd returns its prior value.
REQ-034 SHALL cover: with RF_BYPASS_EN, we=1, rd=31, wdata=12345678, rs2=31 -> rsp_op2=12345678 after 3 cycles, with rf_read_or_write=11 for one cycle.
REQ-035 SHALL cover: 32 back-to-back read-only requests after reset with rs1=rs2=i -> all operands are 0.
